// File: rtl/contrast_stretch_axis.sv
// contrast_stretch_axis: per-frame linear contrast stretch on AXI4-Stream, coefficients from previous frame's min/max
module contrast_stretch_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic [DATA_WIDTH-1:0] contrast_threshold_param,
  input  logic [DATA_WIDTH-1:0] binary_threshold_param,
  input  logic                  thresholding_en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] frame_min,
  output logic [DATA_WIDTH-1:0] frame_max
);
  localparam int W  = DATA_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int N  = W + F;
  localparam int P  = 2 * W + F;
  localparam int P1 = P + 1;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] ONE  = N'(1) << F;
  localparam logic [N-1:0] DVD  = {{W{1'b1}}, {F{1'b0}}};
  localparam logic [P:0]   HALF = P1'(1) << (F - 1);
  localparam logic [P:0]   MAXV = P1'({W{1'b1}});

  typedef enum logic [1:0] {RUN, DIV, COMMIT} state_t;
  state_t state, state_nx;

  logic          en, stall, accept, frame_seen, coef_fresh, last_div, ge, ident;
  logic [W-1:0]  run_min, run_max, range, rem, rem_sub, min_c;
  logic [W:0]    rem_sh;
  logic [N-1:0]  quo, scale;
  logic [CW-1:0] cnt;

  assign en            = !m_axis_tvalid | m_axis_tready;
  assign stall         = s_axis_tvalid & s_axis_tuser & frame_seen & !coef_fresh;
  assign s_axis_tready = i_sys_aresetn & en & (state == RUN) & !stall;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign last_div      = cnt == CW'(N - 1);
  assign rem_sh        = {rem, quo[N-1]};
  assign ge            = rem_sh >= {1'b0, range};
  assign rem_sub       = rem_sh[W-1:0] - range;
  assign ident         = (range < contrast_threshold_param) || (range == '0);

  always_comb begin
    state_nx = state;
    if (state == RUN && stall) state_nx = DIV;
    else if (state == DIV && last_div) state_nx = COMMIT;
    else if (state == COMMIT) state_nx = RUN;
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      state      <= RUN;
      frame_seen <= 1'b0;
      coef_fresh <= 1'b0;
      run_min    <= '0;
      run_max    <= '0;
      range      <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      min_c      <= '0;
      scale      <= ONE;
      frame_min  <= '0;
      frame_max  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        run_min    <= (s_axis_tuser || s_axis_tdata < run_min) ? s_axis_tdata : run_min;
        run_max    <= (s_axis_tuser || s_axis_tdata > run_max) ? s_axis_tdata : run_max;
        frame_seen <= 1'b1;
        coef_fresh <= 1'b0;
      end
      if (state == RUN && stall) begin
        range <= run_max - run_min;
        rem   <= '0;
        quo   <= DVD;
        cnt   <= '0;
      end
      // restoring divide: quotient bits shift in as the dividend shifts out
      if (state == DIV) begin
        rem <= ge ? rem_sub : rem_sh[W-1:0];
        quo <= {quo[N-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) begin
        min_c      <= ident ? '0 : run_min;
        scale      <= ident ? ONE : quo;
        frame_min  <= run_min;
        frame_max  <= run_max;
        coef_fresh <= 1'b1;
      end
    end
  end

  logic         v1, u1, l1, v2, u2, l2;
  logic [W-1:0] d1, y_sat, y;
  logic [N-1:0] sc1;
  logic [P-1:0] prod2;
  logic [P:0]   rnd, shf;

  assign rnd   = {1'b0, prod2} + HALF;
  assign shf   = rnd >> F;
  assign y_sat = (shf > MAXV) ? '1 : shf[W-1:0];
  assign y     = thresholding_en ? {W{y_sat >= binary_threshold_param}} : y_sat;

  // each stage carries its own scale so a COMMIT never touches pixels in flight
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      v1            <= 1'b0;
      u1            <= 1'b0;
      l1            <= 1'b0;
      d1            <= '0;
      sc1           <= ONE;
      v2            <= 1'b0;
      u2            <= 1'b0;
      l2            <= 1'b0;
      prod2         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (en) begin
      v1            <= accept;
      u1            <= accept & s_axis_tuser;
      l1            <= accept & s_axis_tlast;
      d1            <= (s_axis_tdata > min_c) ? s_axis_tdata - min_c : '0;
      sc1           <= scale;
      v2            <= v1;
      u2            <= u1;
      l2            <= l1;
      prod2         <= P'(d1) * P'(sc1);
      m_axis_tvalid <= v2;
      m_axis_tuser  <= u2;
      m_axis_tlast  <= l2;
      m_axis_tdata  <= y;
    end
  end
endmodule

// File: tb/tb_contrast_stretch_axis.sv
// tb_contrast_stretch_axis: directed frames checked against a frame-level contrast-stretch model
module tb_contrast_stretch_axis;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [7:0] ctp = 8'd16, btp = 8'd128;
  logic       thr = 0;
  logic [7:0] s_d = 0;
  logic       s_v = 0, s_u = 0, s_l = 0, s_r;
  logic [7:0] m_d, fmin, fmax;
  logic       m_v, m_u, m_l, m_r = 1;

  contrast_stretch_axis dut (
    .i_sys_clk(clk), .i_sys_aresetn(rst_n),
    .contrast_threshold_param(ctp), .binary_threshold_param(btp), .thresholding_en(thr),
    .s_axis_tdata(s_d), .s_axis_tvalid(s_v), .s_axis_tuser(s_u), .s_axis_tlast(s_l), .s_axis_tready(s_r),
    .m_axis_tdata(m_d), .m_axis_tvalid(m_v), .m_axis_tuser(m_u), .m_axis_tlast(m_l), .m_axis_tready(m_r),
    .frame_min(fmin), .frame_max(fmax)
  );

  int checks = 0, errors = 0;
  int mn = 0, mx = 0, mc = 0, sc = 256, fm = 0, fx = 0;
  bit seen = 0;
  typedef struct {int d; bit u; bit l;} beat_t;
  beat_t expq[$];
  int obs[$];
  int lit_a[$] = '{50, 100, 150, 200};
  int lit_b[$] = '{0, 85, 170, 255, 0, 255};
  int lit_t[$] = '{0, 255};
  int lit_c[$] = '{79, 85, 91};
  int lit_d[$] = '{77, 90, 120, 60, 200, 10};
  int lit_f[$] = '{40, 220};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int px(input int p);
    int d, y;
    d = (p > mc) ? p - mc : 0;
    y = (d * sc + 128) / 256;
    if (y > 255) y = 255;
    if (thr) y = (y >= btp) ? 255 : 0;
    return y;
  endfunction

  task automatic send(input int d, input bit u, input bit l, input bit chk_stall);
    int cnt, r;
    bit st;
    beat_t b;
    cnt = 0;
    st = u && seen;
    @(negedge clk);
    s_d = 8'(d); s_v = 1; s_u = u; s_l = l;
    #1;
    while (!s_r && cnt < 200) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel %0d never accepted", d);
      s_v = 0;
      return;
    end
    if (chk_stall) chk(st ? "sof_stall_cycles" : "no_stall_cycles", cnt, st ? 18 : 0);
    @(posedge clk);
    #1 s_v = 0;
    if (st) begin
      r = mx - mn;
      if (r < ctp || r == 0) begin mc = 0; sc = 256; end
      else begin mc = mn; sc = 65280 / r; end
      fm = mn; fx = mx;
      chk("frame_min", fmin, fm);
      chk("frame_max", fmax, fx);
    end
    b.d = px(d); b.u = u; b.l = l;
    expq.push_back(b);
    if (u || d < mn) mn = d;
    if (u || d > mx) mx = d;
    seen = 1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs missing", expq.size());
      expq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic lit(input string nm, input int e[$]);
    chk({nm, "_count"}, obs.size(), e.size());
    for (int i = 0; i < e.size() && i < obs.size(); i++) chk(nm, obs[i], e[i]);
    obs.delete();
  endtask

  bit hold = 0;
  logic [7:0] hd;
  logic hu, hl;
  beat_t ob;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) hold = 0;
    else begin
      if (hold) begin
        chk("hold_valid", m_v, 1);
        chk("hold_data", m_d, hd);
        chk("hold_user", m_u, hu);
        chk("hold_last", m_l, hl);
      end
      if (m_v && !m_r) chk("tready_when_full", s_r, 0);
      if (m_v && m_r) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", m_d);
        end else begin
          ob = expq.pop_front();
          chk("out_data", m_d, ob.d);
          chk("out_user", m_u, ob.u);
          chk("out_last", m_l, ob.l);
          obs.push_back(int'(m_d));
        end
      end
      hold = m_v && !m_r;
      hd = m_d; hu = m_u; hl = m_l;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tready", s_r, 0);
    chk("rst_mvalid", m_v, 0);
    chk("rst_mdata", m_d, 0);
    chk("rst_fmin", fmin, 0);
    chk("rst_fmax", fmax, 0);
    rst_n = 1;
    // first frame passes with identity, 3-cycle latency
    send(50, 1, 0, 1);
    @(negedge clk); #3 chk("latency_c1", m_v, 0);
    @(negedge clk); #3 chk("latency_c2", m_v, 0);
    @(negedge clk); #3 chk("latency_c3", m_v, 1);
    send(100, 0, 0, 1);
    send(150, 0, 0, 1);
    send(200, 0, 1, 1);
    drain();
    lit("first_frame", lit_a);
    // stretch with 50..200 statistics
    send(50, 1, 0, 1);
    send(100, 0, 0, 1);
    send(150, 0, 0, 1);
    send(200, 0, 0, 1);
    send(30, 0, 0, 1);
    send(255, 0, 1, 1);
    drain();
    lit("stretch", lit_b);
    thr = 1;
    send(100, 0, 0, 1);
    send(150, 0, 1, 1);
    drain();
    thr = 0;
    lit("threshold", lit_t);
    // 30..255 statistics, then a low-range frame
    send(100, 1, 0, 1);
    send(105, 0, 0, 1);
    send(110, 0, 1, 1);
    drain();
    lit("wide_range", lit_c);
    send(77, 1, 0, 1);
    send(90, 0, 0, 1);
    send(120, 0, 0, 1);
    @(negedge clk);
    m_r = 0;
    fork
      begin
        send(60, 0, 0, 0);
        send(200, 0, 0, 0);
        send(10, 0, 1, 0);
      end
      begin
        repeat (5) @(negedge clk);
        m_r = 1;
      end
    join
    drain();
    lit("low_range_bp", lit_d);
    // reset in the middle of a divide
    @(negedge clk);
    s_d = 8'd99; s_v = 1; s_u = 1; s_l = 0;
    repeat (5) @(negedge clk);
    #1 chk("div_tready", s_r, 0);
    rst_n = 0;
    @(negedge clk);
    #1;
    chk("rst_div_tready", s_r, 0);
    chk("rst_div_mvalid", m_v, 0);
    chk("rst_div_mdata", m_d, 0);
    chk("rst_div_muser", m_u, 0);
    chk("rst_div_mlast", m_l, 0);
    chk("rst_div_fmin", fmin, 0);
    chk("rst_div_fmax", fmax, 0);
    mn = 0; mx = 0; mc = 0; sc = 256; fm = 0; fx = 0; seen = 0;
    s_v = 0;
    rst_n = 1;
    send(40, 1, 0, 1);
    send(220, 0, 1, 1);
    drain();
    lit("after_reset", lit_f);
    chk("fmin_after_reset", fmin, fm);
    chk("fmax_after_reset", fmax, fx);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/contrast_stretch_axis.md
# contrast_stretch_axis

Per-frame linear contrast stretch on an AXI4-Stream video channel. It is the parametrised successor to the histogram-equalisation stage: pixel width and fixed-point precision are generic, output backpressure is supported, and binary thresholding is optional. Each frame is stretched using the min/max statistics of the previous frame. Scale is computed by a sequential divider while input is stalled at start-of-frame.

## Interface
- DATA_WIDTH, 8, pixel width in bits.
- FRAC_BITS, 8, fractional bits of the scale coefficient.
- i_sys_clk  in  1  the single clock; everything is sampled on its rising edge.
- i_sys_aresetn  in  1  synchronous, active-low reset.
- contrast_threshold_param  in  DATA_WIDTH  minimum frame range (max−min) for which stretching is applied.
- binary_threshold_param  in  DATA_WIDTH  binarisation level.
- thresholding_en  in  1  1 = binarise the stretched output.
- s_axis_tdata/tvalid/tuser/tlast  in  DATA_WIDTH/1/1/1  input pixel, valid, start-of-frame, end-of-line.
- s_axis_tready  out  1  input accept.
- m_axis_tdata/tvalid/tuser/tlast  out  DATA_WIDTH/1/1/1  output pixel and sidebands.
- m_axis_tready  in  1  downstream accept.
- frame_min, frame_max  out  DATA_WIDTH each  statistics of the last committed frame.

## Operation
- **FSM states:** RUN, DIV, COMMIT.
- **Statistics:** on every accepted input beat:
  - tuser=1: run_min = run_max = tdata;
  - otherwise: run_min = min(run_min, tdata), run_max = max(run_max, tdata).
  - frame_seen is set on the first accepted beat after reset.
- **SOF stall:**
  - Condition: RUN with s_axis_tvalid=1, s_axis_tuser=1, frame_seen=1 and coef_fresh=0.
  - That beat is refused (s_axis_tready=0) and the FSM enters DIV.
  - DIV latches range = run_max − run_min.
- **DIV:** restoring divider, one quotient bit per cycle for DATA_WIDTH+FRAC_BITS cycles. It computes scale = floor(((2^DATA_WIDTH−1) << FRAC_BITS) / range); scale is DATA_WIDTH+FRAC_BITS bits.
- **COMMIT (1 cycle):**
  - If range < contrast_threshold_param or range = 0: active coefficients become identity (min_c=0, scale=1<<FRAC_BITS).
  - Otherwise: min_c = run_min, scale = quotient.
  - frame_min/frame_max ← run_min/run_max.
  - coef_fresh ← 1. Return to RUN.
- The held SOF beat is then accepted; acceptance clears coef_fresh.
- **Pipeline:** 3 stages with a global enable en = !m_axis_tvalid | m_axis_tready. Each stage carries its own coefficient copy, so pixels in flight are never affected by COMMIT.
  - S1: d = (p > min_c) ? p − min_c : 0, width DATA_WIDTH.
  - S2: prod = d × scale, full width 2·DATA_WIDTH+FRAC_BITS.
  - S3: y = (prod + 2^(FRAC_BITS−1)) >> FRAC_BITS, saturated to 2^DATA_WIDTH−1.
  - If thresholding_en: y = (y ≥ binary_threshold_param) ? all-ones : 0. thresholding_en is sampled in S3.
- tuser and tlast travel with the data unchanged.
- **Defaults:** the first frame after reset passes with identity coefficients (output = input). Pixels outside the previous frame's range clamp to 0 or to full-scale.

## Timing
- **Reset (i_sys_aresetn=0 at a clock edge):**
  - Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, frame_min=0, frame_max=0.
  - State: FSM→RUN, coefficients→identity, frame_seen=0, coef_fresh=0.
  - Reset during DIV aborts the divide; no commit occurs.
- **s_axis_tready:** combinational, = en & (state==RUN) & !(s_axis_tvalid & s_axis_tuser & frame_seen & !coef_fresh), forced 0 in reset. Depending on tvalid is legal.
- **Latency:** 3 enabled cycles from input acceptance to m_axis_tvalid.
- **Throughput:** 1 pixel/cycle when m_axis_tready=1.
- **SOF stall:** s_axis_tready is low for exactly DATA_WIDTH+FRAC_BITS+2 cycles (18 for defaults), assuming en=1: 1 refusal cycle, the DIV cycles, and COMMIT.
  - The divider keeps running when en=0.
  - The pipeline keeps draining during the stall.
- **Output hold:** while m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs are held stable.
- **Edge cases:**
  - An SOF beat arriving while coef_fresh=1 is accepted without a further stall.
  - A single-pixel frame gives range=0, so identity is committed.
  - Back-to-back SOF beats each stall.

## Test plan
All scenarios use the defaults DATA_WIDTH=8, FRAC_BITS=8, with contrast_threshold_param=16 and binary_threshold_param=128.
- **First frame after reset:** frame [50,100,150,200] (tuser on 50, tlast on 200) → outputs [50,100,150,200] 3 cycles after each accept; no stall.
- **Stretch:** next frame SOF → s_axis_tready low 18 cycles; frame_min=50, frame_max=200, scale=435. Pixels [50,100,150,200,30,255] → outputs [0,85,170,255,0,255].
- **Low range:** frame [100,105,110] then a new frame → 18-cycle stall; identity committed; pixel 77 → 77.
- **Thresholding:** with the scenario-2 coefficients and thresholding_en=1, pixels [100,150] → [0,255].
- **Backpressure:** m_axis_tready=0 for 5 cycles mid-frame → m_axis_* held stable; no loss or reordering; s_axis_tready=0 once the pipeline is full.
- **Reset in DIV:** i_sys_aresetn=0 during cycle 5 of DIV → all outputs reset. After release, the next SOF is accepted with no stall and passes with identity.
